ttt_game_controller: RTL and testbench

Sequencing controller for the tic-tac-toe board. Owns the nine 2-bit cell registers that feed the scanline renderer (`board1`..`board9`). Accepts move requests through a valid/ready handshake, alternates turns, and rejects illegal moves. After every accepted move it evaluates the eight winning lines and reports win, draw, or the next turn.

---
 rtl/ttt_pkg.sv | 25 ++
 rtl/ttt_line_check.sv | 16 +
 rtl/ttt_game_controller.sv | 129 ++++++++++++
 tb/tb_ttt_game_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell/winner encodings, controller states and the winning-line table.
package ttt_pkg;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  typedef enum logic [1:0] {TURN, CHECK, OVER} state_e;
  // Zero-based cell indices per line: rows, columns, main diagonal, anti-diagonal.
  localparam logic [7:0][2:0][3:0] LINE_CELLS = {
    {4'd2, 4'd4, 4'd6},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8},
    {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5},
    {4'd0, 4'd1, 4'd2}
  };
  function automatic logic [1:0] mark_of(input logic player);
    return player ? CELL_O : CELL_X;
  endfunction
endpackage

// File: rtl/ttt_line_check.sv
// ttt_line_check: flags every line whose three cells all hold the given mark.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  input  logic [1:0]  mark_i,
  output logic [7:0]  win_lines_o
);
  logic [8:0][1:0] cells;
  assign cells = board_i;
  for (genvar l = 0; l < 8; l++) begin : g_line
    assign win_lines_o[l] = (cells[LINE_CELLS[l][0]] == mark_i) &&
                            (cells[LINE_CELLS[l][1]] == mark_i) &&
                            (cells[LINE_CELLS[l][2]] == mark_i);
  end
endmodule

// File: rtl/ttt_game_controller.sv
// ttt_game_controller: owns the board, takes moves by handshake and scores each accepted move.
module ttt_game_controller
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       move_ack,
  output logic       move_err,
  output logic [1:0] board1,
  output logic [1:0] board2,
  output logic [1:0] board3,
  output logic [1:0] board4,
  output logic [1:0] board5,
  output logic [1:0] board6,
  output logic [1:0] board7,
  output logic [1:0] board8,
  output logic [1:0] board9,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] win_lines,
  output logic [3:0] move_count
);
  state_e          state_q, state_d;
  logic [8:0][1:0] cells_q, cells_d;
  logic            turn_q, turn_d;
  logic [3:0]      count_q, count_d;
  logic [1:0]      winner_q, winner_d;
  logic [7:0]      lines_q, lines_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            hs, cell_ok, legal;
  logic [3:0]      idx;
  logic [1:0]      mark;
  logic [7:0]      lines;
  assign hs      = move_valid && state_q == TURN;
  assign cell_ok = move_cell >= 4'd1 && move_cell <= 4'd9;
  assign idx     = cell_ok ? move_cell - 4'd1 : 4'd0;
  assign legal   = cell_ok && cells_q[idx] == CELL_EMPTY;
  assign mark    = mark_of(turn_q);
  ttt_line_check u_line_check (
    .board_i    (cells_q),
    .mark_i     (mark),
    .win_lines_o(lines)
  );
  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    turn_d   = turn_q;
    count_d  = count_q;
    winner_d = winner_q;
    lines_d  = lines_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    if (new_game) begin
      state_d  = TURN;
      cells_d  = '0;
      turn_d   = FIRST_PLAYER;
      count_d  = '0;
      winner_d = WIN_NONE;
      lines_d  = '0;
    end else begin
      case (state_q)
        TURN: begin
          if (hs && legal) begin
            cells_d[idx] = mark;
            count_d      = count_q + 4'd1;
            ack_d        = 1'b1;
            state_d      = CHECK;
          end else if (hs) begin
            err_d = 1'b1;
          end
        end
        CHECK: begin
          lines_d  = lines;
          winner_d = |lines ? (turn_q ? WIN_O : WIN_X) : (count_q == 4'd9 ? WIN_DRAW : WIN_NONE);
          state_d  = (|lines || count_q == 4'd9) ? OVER : TURN;
          turn_d   = (|lines || count_q == 4'd9) ? turn_q : ~turn_q;
        end
        OVER:    state_d = OVER;
        default: state_d = TURN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= TURN;
      cells_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      count_q  <= '0;
      winner_q <= WIN_NONE;
      lines_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      lines_q  <= lines_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end
  assign move_ready = state_q == TURN;
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign game_over  = state_q == OVER;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign win_lines  = lines_q;
  assign move_count = count_q;
  assign board1 = cells_q[0];
  assign board2 = cells_q[1];
  assign board3 = cells_q[2];
  assign board4 = cells_q[3];
  assign board5 = cells_q[4];
  assign board6 = cells_q[5];
  assign board7 = cells_q[6];
  assign board8 = cells_q[7];
  assign board9 = cells_q[8];
endmodule

// File: tb/tb_ttt_game_controller.sv
// tb_ttt_game_controller: directed move sequences with hand-computed board/score expectations.
module tb_ttt_game_controller;
  logic       clk = 1'b0;
  logic       rst_n, new_game, move_valid;
  logic [3:0] move_cell;
  logic       move_ready, move_ack, move_err, turn, game_over;
  logic [1:0] board1, board2, board3, board4, board5, board6, board7, board8, board9, winner;
  logic [7:0] win_lines;
  logic [3:0] move_count;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  ttt_game_controller #(.FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid), .move_cell(move_cell),
    .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
    .board1(board1), .board2(board2), .board3(board3), .board4(board4), .board5(board5),
    .board6(board6), .board7(board7), .board8(board8), .board9(board9),
    .turn(turn), .game_over(game_over), .winner(winner), .win_lines(win_lines), .move_count(move_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ng();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask
  // Legal move: ack and not-ready one cycle after handshake, scoring visible the cycle after.
  task automatic play(input logic [3:0] c);
    move_valid = 1'b1;
    move_cell  = c;
    step();
    move_valid = 1'b0;
    chk("play_ack", move_ack, 1);
    chk("play_ready_low", move_ready, 0);
    step();
  endtask
  task automatic bad(input logic [3:0] c);
    move_valid = 1'b1;
    move_cell  = c;
    step();
    move_valid = 1'b0;
    chk("bad_err", move_err, 1);
    chk("bad_noack", move_ack, 0);
    chk("bad_ready", move_ready, 1);
    step();
    chk("bad_err_once", move_err, 0);
  endtask
  task automatic ignored(input logic [3:0] c);
    move_valid = 1'b1;
    move_cell  = c;
    step();
    move_valid = 1'b0;
    chk("ign_ack", move_ack, 0);
    chk("ign_err", move_err, 0);
  endtask
  initial begin
    rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_board", {board9, board8, board7, board6, board5, board4, board3, board2, board1}, 0);
    chk("rst_turn", turn, 0);
    chk("rst_ready", move_ready, 1);
    chk("rst_count", move_count, 0);
    chk("rst_winner", winner, 0);
    chk("rst_over", game_over, 0);
    chk("rst_ack", move_ack, 0);
    chk("rst_err", move_err, 0);
    // X wins on the top row
    play(1);
    chk("m1_board1", board1, 2'b01);
    chk("m1_turn", turn, 1);
    chk("m1_count", move_count, 1);
    chk("m1_ready", move_ready, 1);
    play(4);
    chk("m2_board4", board4, 2'b10);
    play(2); play(5); play(3);
    chk("row_winner", winner, 2'b01);
    chk("row_lines", win_lines, 8'b0000_0001);
    chk("row_over", game_over, 1);
    chk("row_count", move_count, 5);
    chk("row_ready", move_ready, 0);
    ignored(9);
    chk("row_frozen9", board9, 2'b00);
    // Illegal moves
    ng();
    chk("ng_over", game_over, 0);
    chk("ng_winner", winner, 0);
    play(5);
    bad(5);
    chk("ill_board5", board5, 2'b01);
    chk("ill_turn", turn, 1);
    bad(0);
    bad(12);
    chk("ill_count", move_count, 1);
    // Draw
    ng();
    play(1); play(2); play(3); play(5); play(4); play(6); play(8); play(7); play(9);
    chk("draw_winner", winner, 2'b11);
    chk("draw_lines", win_lines, 0);
    chk("draw_count", move_count, 9);
    chk("draw_over", game_over, 1);
    // 1,2,5,3,7,6,4: X holds 1,4,7 after the seventh mark, so column 1 ends the game there
    ng();
    play(1); play(2); play(5); play(3); play(7); play(6); play(4);
    chk("col_winner", winner, 2'b01);
    chk("col_lines", win_lines, 8'b0000_1000);
    chk("col_count", move_count, 7);
    ignored(8);
    chk("col_frozen8", board8, 2'b00);
    // X at cell 1 completes column 1 and the main diagonal together on the ninth mark
    ng();
    play(4); play(2); play(7); play(3); play(5); play(6); play(9); play(8); play(1);
    chk("dbl_winner", winner, 2'b01);
    chk("dbl_lines", win_lines, 8'b0100_1000);
    chk("dbl_count", move_count, 9);
    // new_game beats a simultaneous move
    ng();
    play(1);
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd5;
    step();
    new_game = 1'b0; move_valid = 1'b0;
    chk("ngp_ack", move_ack, 0);
    chk("ngp_err", move_err, 0);
    chk("ngp_board5", board5, 2'b00);
    chk("ngp_board1", board1, 2'b00);
    chk("ngp_turn", turn, 0);
    chk("ngp_count", move_count, 0);
    chk("ngp_ready", move_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
